// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// States, the all-ones quotient returned on divide-by-zero, and the step-counter width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH = 8;

    localparam logic DIV_QUOT_FILL = 1'b1;
    localparam logic [DIV_WIDTH-1:0] DIV_QUOT_ON_ZERO = {DIV_WIDTH{DIV_QUOT_FILL}};

    // The counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
// master drives operands and start; slave (the divider) returns status and results.
interface div_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// then compare/subtract against the divisor on a WIDTH+1-bit datapath.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] p_in,
    input  logic             d_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] p_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] divisor_ext;

    // p_in < divisor is invariant, so the shifted value needs one extra bit
    // but the difference always fits back into WIDTH bits.
    always_comb begin
        shifted     = {p_in, d_msb};
        divisor_ext = {1'b0, divisor};
        q_bit       = (shifted >= divisor_ext);
        p_out       = q_bit ? WIDTH'(shifted - divisor_ext) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIVIDER_EARLY_TERM_EN to finish immediately when dividend < divisor.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    div_if.slave  bus
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_p;
    logic             step_q_bit;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_in    (p_q),
        .d_msb   (d_q[WIDTH-1]),
        .divisor (divisor_q),
        .p_out   (step_p),
        .q_bit   (step_q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            d_q         <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            d_q         <= d_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // d_q doubles as the quotient shift register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        d_d         = d_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    d_d       = bus.dividend;
                    divisor_d = bus.divisor;
                    p_d       = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    if (bus.divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = {WIDTH{DIV_QUOT_FILL}};
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end
`ifdef DIVIDER_EARLY_TERM_EN
                    else if (bus.dividend < bus.divisor) begin
                        state_d     = DONE;
                        quotient_d  = '0;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b0;
                    end
`endif
                    else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                p_d   = step_p;
                d_d   = {d_q[WIDTH-2:0], step_q_bit};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    quotient_d  = {d_q[WIDTH-2:0], step_q_bit};
                    remainder_d = step_p;
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8): directed vector table,
// hand-written handshake/reset sequences and a random sweep against a / and % model.
module tb_seq_restoring_divider;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    div_if #(.WIDTH(8)) bus();

    seq_restoring_divider #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[12];

    int checks = 0;
    int passed = 0;
    int donePulses = 0;

    // Every cycle with done high spans exactly one falling edge.
    always @(negedge clk) begin
        if (bus.done === 1'b1) donePulses++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int expLat(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return 0;
`ifdef DIVIDER_EARLY_TERM_EN
        if (a < b) return 0;
`endif
        return 8;
    endfunction

    // Launches one operation; lat counts edges after the accepting edge until done is seen.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 output int lat, output int busyCycles);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = b ^ 8'h5A;
        lat = 0;
        busyCycles = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busyCycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.busy === 1'b1) busyCycles++;
    endtask

    task automatic runVector(input string tag, input vec_t v, input bit full);
        int lat;
        int busyCycles;
        int p0;
        p0 = donePulses;
        applyStimulus(v.a, v.b, lat, busyCycles);
        checkOutput({tag, " quotient"}, 32'(bus.quotient), 32'(v.q));
        checkOutput({tag, " remainder"}, 32'(bus.remainder), 32'(v.r));
        checkOutput({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(v.z));
        if (full) begin
            checkOutput({tag, " latency"}, 32'(lat), 32'(expLat(v.a, v.b)));
            checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(expLat(v.a, v.b) + 1));
        end
        @(posedge clk);
        #1;
        if (full) begin
            checkOutput({tag, " done width"}, 32'(bus.done), 32'd0);
            checkOutput({tag, " busy after"}, 32'(bus.busy), 32'd0);
            checkOutput({tag, " hold quotient"}, 32'(bus.quotient), 32'(v.q));
        end
        checkOutput({tag, " done pulses"}, 32'(donePulses - p0), 32'd1);
    endtask

    initial begin
        int lat;
        int busyCycles;
        int p0;
        vec_t v;

        vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
        vecs[1]  = '{8'd13,  8'd0,   8'd255, 8'd13,  1'b1};
        vecs[2]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[3]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        vecs[4]  = '{8'd50,  8'd6,   8'd8,   8'd2,   1'b0};
        vecs[5]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        vecs[7]  = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0};
        vecs[8]  = '{8'd128, 8'd200, 8'd0,   8'd128, 1'b0};
        vecs[9]  = '{8'd255, 8'd254, 8'd1,   8'd1,   1'b0};
        vecs[10] = '{8'd100, 8'd3,   8'd33,  8'd1,   1'b0};
        vecs[11] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset quotient", 32'(bus.quotient), 32'd0);
        checkOutput("reset remainder", 32'(bus.remainder), 32'd0);
        checkOutput("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i], 1'b1);
        end

        // A start pulse in the middle of RUN must not disturb the active operation.
        p0 = donePulses;
        @(negedge clk);
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.dividend = 8'd100;
        bus.divisor  = 8'd3;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("ignored start quotient", 32'(bus.quotient), 32'd28);
        checkOutput("ignored start remainder", 32'(bus.remainder), 32'd4);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("ignored start done pulses", 32'(donePulses - p0), 32'd1);
        checkOutput("ignored start busy", 32'(bus.busy), 32'd0);

        // Reset during the fourth RUN cycle discards the operation.
        p0 = donePulses;
        @(negedge clk);
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrun reset busy", 32'(bus.busy), 32'd0);
        checkOutput("midrun reset done", 32'(bus.done), 32'd0);
        checkOutput("midrun reset quotient", 32'(bus.quotient), 32'd0);
        checkOutput("midrun reset remainder", 32'(bus.remainder), 32'd0);
        checkOutput("midrun reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("midrun reset no done", 32'(donePulses - p0), 32'd0);
        runVector("after reset 50/6", vecs[4], 1'b1);

        // Start held high: back-to-back operations separated by one IDLE cycle.
        @(negedge clk);
        bus.dividend = 8'd100;
        bus.divisor  = 8'd3;
        bus.start    = 1'b1;
        p0 = donePulses;
        repeat (25) @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("held start done pulses", 32'(donePulses - p0), 32'd2);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("held start quotient", 32'(bus.quotient), 32'd33);

        for (int n = 0; n < 2000; n++) begin
            int sa;
            int sb;
            sa = $urandom_range(0, 9);
            sb = $urandom_range(0, 9);
            v.a = (sa == 0) ? 8'd0 : (sa == 1) ? 8'd1 : (sa == 2) ? 8'd255 : 8'($urandom_range(0, 255));
            v.b = (sb == 0) ? 8'd0 : (sb == 1) ? 8'd1 : (sb == 2) ? 8'd255 : 8'($urandom_range(0, 255));
            if (v.b == 8'd0) begin
                v.q = 8'd255;
                v.r = v.a;
                v.z = 1'b1;
            end else begin
                v.q = v.a / v.b;
                v.r = v.a % v.b;
                v.z = 1'b0;
            end
            runVector($sformatf("rand%0d %0d/%0d", n, v.a, v.b), v, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
